// File: rtl/crc_check_if.sv
// Frame-in / verdict-out bundle between the link receive register and the CRC checker.
interface crc_check_if;
    logic         we;
    logic [127:0] dataIn;
    logic [95:0]  data;
    logic [15:0]  q;
    logic         rdy;
    logic         ok;
    logic         err;
    logic         busy;
    logic [7:0]   errCnt;

    modport master (
        output we, dataIn,
        input  data, q, rdy, ok, err, busy, errCnt
    );

    modport slave (
        input  we, dataIn,
        output data, q, rdy, ok, err, busy, errCnt
    );
endinterface

// File: rtl/crc_check.sv
// Receive-side CRC-16-CCITT checker: folds the 96-bit payload NUMB bits per clock,
// then compares against the carried CRC and checks the reserved field.
module crc_check #(
    parameter int unsigned NUMB = 16
) (
    input  logic       clk,
    input  logic       rst,
    crc_check_if.slave bus
);

    localparam int unsigned PAY_W  = 96;
    localparam int unsigned CRC_W  = 16;
    localparam int unsigned NCHUNK = PAY_W / NUMB;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam logic [CRC_W-1:0] POLY     = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [127:0]     frame_q, frame_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CRC_W-1:0] q_q, q_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic [7:0]       errcnt_q, errcnt_d;

    logic [6:0]       shamt;
    logic [PAY_W-1:0] pay_shifted;
    logic [NUMB-1:0]  chunk;
    logic [CRC_W-1:0] crc_next;
    logic             pass;

    // Unrolled bit-serial CRC update, MSB of the chunk first.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] c_in,
                                              input logic [NUMB-1:0]  d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = int'(NUMB) - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
        return c;
    endfunction

    // Chunk k sits at payload[95-k*NUMB -: NUMB]; shift it up to the top.
    always_comb begin
        shamt       = 7'(32'(cnt_q) * NUMB);
        pay_shifted = frame_q[127:32] << shamt;
        chunk       = pay_shifted[PAY_W-1 -: NUMB];
        crc_next    = fold(crc_q, chunk);
        pass        = (crc_next == frame_q[31:16]) && (frame_q[15:0] == 16'h0000);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.we) state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and verdict; verdict registers hold until the next capture clears them.
    always_comb begin
        frame_d  = frame_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        ok_d     = ok_q;
        err_d    = err_q;
        rdy_d    = 1'b0;
        busy_d   = busy_q;
        errcnt_d = errcnt_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.we) begin
                    frame_d = bus.dataIn;
                    crc_d   = CRC_INIT;
                    cnt_d   = '0;
                    q_d     = '0;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_CALC: begin
                busy_d = 1'b1;
                crc_d  = crc_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    q_d   = crc_next;
                    ok_d  = pass;
                    err_d = !pass;
                    rdy_d = 1'b1;
                    if (!pass && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q  <= '0;
            crc_q    <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            frame_q  <= frame_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.data   = frame_q[127:32];
    assign bus.q      = q_q;
    assign bus.ok     = ok_q;
    assign bus.err    = err_q;
    assign bus.rdy    = rdy_q;
    assign bus.busy   = busy_q;
    assign bus.errCnt = errcnt_q;

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: three instances (NUMB 16, 8, 32) against a
// polynomial-division CRC model.
module tb_crc_check;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         we16 = 1'b0, we8 = 1'b0, we32 = 1'b0;
    logic [127:0] din = '0;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    crc_check_if if16 ();
    crc_check_if if8 ();
    crc_check_if if32 ();

    assign if16.we = we16;  assign if16.dataIn = din;
    assign if8.we  = we8;   assign if8.dataIn  = din;
    assign if32.we = we32;  assign if32.dataIn = din;

    crc_check #(.NUMB(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
    crc_check #(.NUMB(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
    crc_check #(.NUMB(32)) u32 (.clk(clk), .rst(rst), .bus(if32));

    // CRC as the remainder of the augmented message mod x^16+x^12+x^5+1,
    // with the 0xFFFF preset folded into the leading 16 message bits.
    function automatic logic [15:0] crc_model(input logic [95:0] p);
        logic [111:0] m;
        m = {p ^ {16'hFFFF, 80'h0}, 16'h0000};
        for (int i = 111; i >= 16; i--)
            if (m[i]) m[i -: 17] = m[i -: 17] ^ 17'h11021;
        return m[15:0];
    endfunction

    function automatic logic [127:0] mk_frame(input logic [95:0] p, input logic [15:0] c,
                                              input logic [15:0] r);
        return {p, c, r};
    endfunction

    function automatic logic rdy_of(input int w);
        case (w) 8: return if8.rdy; 32: return if32.rdy; default: return if16.rdy; endcase
    endfunction

    function automatic logic [15:0] q_of(input int w);
        case (w) 8: return if8.q; 32: return if32.q; default: return if16.q; endcase
    endfunction

    function automatic logic ok_of(input int w);
        case (w) 8: return if8.ok; 32: return if32.ok; default: return if16.ok; endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present a frame so that the next edge (E0) captures it; returns at E0+#1.
    task automatic start(input int w, input logic [127:0] f);
        din = f;
        case (w) 8: we8 = 1'b1; 32: we32 = 1'b1; default: we16 = 1'b1; endcase
        tick();
        we8 = 1'b0; we16 = 1'b0; we32 = 1'b0;
    endtask

    // Edges after E0 until rdy is seen (-1 if the budget runs out).
    task automatic wait_rdy(input int w, input int max, output int edges);
        edges = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (rdy_of(w)) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (if16.data !== 96'h0)   begin errors++; $display("FAIL reset_data got %h want 0", if16.data); end
        checks++; if (if16.q !== 16'h0)      begin errors++; $display("FAIL reset_q got %h want 0", if16.q); end
        checks++; if ({if16.rdy, if16.ok, if16.err, if16.busy} !== 4'b0000)
                  begin errors++; $display("FAIL reset_flags got %b want 0000", {if16.rdy, if16.ok, if16.err, if16.busy}); end
        checks++; if (if16.errCnt !== 8'h00) begin errors++; $display("FAIL reset_errcnt got %h want 00", if16.errCnt); end
    endtask

    task automatic test_good();
        logic [95:0]  p;
        logic [15:0]  c;
        int           e;
        p = 96'h111122223333444455556666;
        c = crc_model(p);
        start(16, mk_frame(p, c, 16'h0));
        din = '1;
        checks++; if (if16.busy !== 1'b1) begin errors++; $display("FAIL good_busy_rise got %b want 1", if16.busy); end
        checks++; if (if16.data !== p)    begin errors++; $display("FAIL good_data got %h want %h", if16.data, p); end
        wait_rdy(16, 20, e);
        checks++; if (e != 6) begin errors++; $display("FAIL good_latency got %0d want 6", e); end
        checks++; if ({if16.ok, if16.err} !== 2'b10) begin errors++; $display("FAIL good_verdict got ok/err %b want 10", {if16.ok, if16.err}); end
        checks++; if (if16.q !== c) begin errors++; $display("FAIL good_q got %h want %h", if16.q, c); end
        tick();
        checks++; if ({if16.rdy, if16.busy} !== 2'b00) begin errors++; $display("FAIL good_rdy_width got rdy/busy %b want 00", {if16.rdy, if16.busy}); end
        checks++; if (if16.errCnt !== 8'd0) begin errors++; $display("FAIL good_errcnt got %0d want 0", if16.errCnt); end
        tick();
        checks++; if ({if16.ok, if16.q} !== {1'b1, c}) begin errors++; $display("FAIL good_hold got ok %b q %h want 1 %h", if16.ok, if16.q, c); end
    endtask

    task automatic test_corrupt();
        logic [95:0] p;
        logic [15:0] c;
        int          e;
        p = 96'h111122223333444455556666;
        c = crc_model(p);
        start(16, mk_frame(p ^ 96'h1, c, 16'h0));
        checks++; if ({if16.ok, if16.q} !== 17'h0) begin errors++; $display("FAIL corrupt_clear_on_capture got ok %b q %h want 0 0", if16.ok, if16.q); end
        wait_rdy(16, 20, e);
        exp_cnt++;
        checks++; if ({if16.ok, if16.err} !== 2'b01) begin errors++; $display("FAIL corrupt_verdict got ok/err %b want 01", {if16.ok, if16.err}); end
        checks++; if (if16.q !== crc_model(p ^ 96'h1) || if16.q === c)
                  begin errors++; $display("FAIL corrupt_q got %h want %h (not %h)", if16.q, crc_model(p ^ 96'h1), c); end
        tick();
        checks++; if (int'(if16.errCnt) != exp_cnt) begin errors++; $display("FAIL corrupt_errcnt got %0d want %0d", if16.errCnt, exp_cnt); end
    endtask

    task automatic test_reserved();
        logic [95:0] p;
        int          e;
        p = 96'h111122223333444455556666;
        start(16, mk_frame(p, crc_model(p), 16'h0001));
        wait_rdy(16, 20, e);
        exp_cnt++;
        checks++; if ({if16.ok, if16.err} !== 2'b01) begin errors++; $display("FAIL reserved_verdict got ok/err %b want 01", {if16.ok, if16.err}); end
        checks++; if (if16.q !== crc_model(p)) begin errors++; $display("FAIL reserved_q got %h want %h", if16.q, crc_model(p)); end
        tick(); tick();
        checks++; if (int'(if16.errCnt) != exp_cnt) begin errors++; $display("FAIL reserved_errcnt got %0d want %0d", if16.errCnt, exp_cnt); end
    endtask

    task automatic test_we_busy();
        logic [95:0] pa, pb;
        int          pulses;
        pa = 96'hA5A5_0F0F_1234_5678_9ABC_DEF0;
        pb = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
        start(16, mk_frame(pa, crc_model(pa), 16'h0));
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin
                din  = mk_frame(pb, 16'hDEAD, 16'h0);
                we16 = 1'b1;
            end
            tick();
            if (k == 3) we16 = 1'b0;
            if (if16.rdy) begin
                pulses++;
                checks++; if (if16.ok !== 1'b1) begin errors++; $display("FAIL busy_we_verdict got ok %b want 1", if16.ok); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_we_pulses got %0d want 1", pulses); end
        checks++; if (if16.data !== pa) begin errors++; $display("FAIL busy_we_data got %h want %h", if16.data, pa); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] p;
        int          pulses, e;
        p = 96'hCAFE_BABE_DEAD_BEEF_0000_FFFF;
        start(16, mk_frame(p, crc_model(p), 16'h0));
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if ({if16.data, if16.q, if16.rdy, if16.ok, if16.err, if16.busy, if16.errCnt} !== '0)
                  begin errors++; $display("FAIL midreset_async got data %h q %h flags %b cnt %0d want all 0",
                        if16.data, if16.q, {if16.rdy, if16.ok, if16.err, if16.busy}, if16.errCnt); end
        tick();
        rst = 1'b1;
        exp_cnt = 0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (if16.rdy) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_no_rdy got %0d pulses want 0", pulses); end
        start(16, mk_frame(p, crc_model(p), 16'h0));
        wait_rdy(16, 20, e);
        checks++; if (e != 6 || if16.ok !== 1'b1) begin errors++; $display("FAIL midreset_next_frame got lat %0d ok %b want 6 1", e, if16.ok); end
        tick();
    endtask

    task automatic test_random();
        logic [95:0] p;
        logic [15:0] c;
        logic [15:0] r;
        logic        good;
        int          kind, e;
        for (int n = 0; n < 24; n++) begin
            p    = {$urandom, $urandom, $urandom};
            kind = $urandom_range(0, 2);
            c    = crc_model(p);
            r    = 16'h0;
            if (kind == 1) c = c ^ 16'(1 << $urandom_range(0, 15));
            if (kind == 2) r = 16'(1 << $urandom_range(0, 15));
            good = (kind == 0);
            start(16, mk_frame(p, c, r));
            wait_rdy(16, 20, e);
            if (!good && exp_cnt < 255) exp_cnt++;
            checks++; if (e != 6 || {if16.ok, if16.err} !== {good, !good} || if16.q !== crc_model(p))
                      begin errors++; $display("FAIL random_%0d got lat %0d ok/err %b q %h want 6 %b %h",
                            n, e, {if16.ok, if16.err}, if16.q, {good, !good}, crc_model(p)); end
            tick();
            checks++; if (int'(if16.errCnt) != exp_cnt) begin errors++; $display("FAIL random_errcnt_%0d got %0d want %0d", n, if16.errCnt, exp_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        logic [95:0] p [3];
        int          e;
        for (int n = 0; n < 3; n++) p[n] = {$urandom, $urandom, $urandom};
        din  = mk_frame(p[0], crc_model(p[0]), 16'h0);
        we16 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_rdy(16, 20, e);
            checks++; if (e < 0 || if16.ok !== 1'b1 || if16.q !== crc_model(p[n]) || if16.data !== p[n])
                      begin errors++; $display("FAIL b2b_%0d got rdy %0d ok %b q %h data %h want ok 1 q %h data %h",
                            n, e, if16.ok, if16.q, if16.data, crc_model(p[n]), p[n]); end
            if (n < 2) din = mk_frame(p[n+1], crc_model(p[n+1]), 16'h0);
        end
        we16 = 1'b0;
        tick(); tick();
        checks++; if (if16.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy %b want 0", if16.busy); end
    endtask

    task automatic test_saturation();
        logic [95:0] p;
        int          e;
        do_reset();
        for (int n = 1; n <= 257; n++) begin
            p = {$urandom, $urandom, $urandom};
            start(16, mk_frame(p, crc_model(p) ^ 16'h8000, 16'h0));
            wait_rdy(16, 20, e);
            checks++; if (e != 6 || if16.err !== 1'b1) begin errors++; $display("FAIL sat_err_%0d got lat %0d err %b want 6 1", n, e, if16.err); end
            tick();
            exp_cnt = (n > 255) ? 255 : n;
            checks++; if (int'(if16.errCnt) != exp_cnt) begin errors++; $display("FAIL sat_cnt_%0d got %0d want %0d", n, if16.errCnt, exp_cnt); end
        end
    endtask

    task automatic test_sweep();
        logic [95:0] p;
        logic [15:0] c;
        int          e;
        p = 96'h111122223333444455556666;
        c = crc_model(p);
        start(8, mk_frame(p, c, 16'h0));
        wait_rdy(8, 30, e);
        checks++; if (e != 12) begin errors++; $display("FAIL sweep8_latency got %0d want 12", e); end
        checks++; if (q_of(8) !== c || ok_of(8) !== 1'b1) begin errors++; $display("FAIL sweep8_q got %h ok %b want %h 1", q_of(8), ok_of(8), c); end
        tick();
        checks++; if (rdy_of(8) !== 1'b0) begin errors++; $display("FAIL sweep8_rdy_width got %b want 0", rdy_of(8)); end
        start(32, mk_frame(p, c, 16'h0));
        wait_rdy(32, 30, e);
        checks++; if (e != 3) begin errors++; $display("FAIL sweep32_latency got %0d want 3", e); end
        checks++; if (q_of(32) !== c || ok_of(32) !== 1'b1) begin errors++; $display("FAIL sweep32_q got %h ok %b want %h 1", q_of(32), ok_of(32), c); end
        tick();
        checks++; if (rdy_of(32) !== 1'b0) begin errors++; $display("FAIL sweep32_rdy_width got %b want 0", rdy_of(32)); end
    endtask

    initial begin
        tick();
        test_reset();
        test_good();
        test_corrupt();
        test_reserved();
        test_we_busy();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_saturation();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
